uart_command_controller: RTL and testbench
==========================================

// Module: uart_command_controller
// PURPOSE
//  Frame decoder and register-bus sequencer behind the UART receiver. Consumes the receiver's
//  valid-strobed byte stream, parses SYNC/CMD/[DATA]/CHECK frames, issues one register read or write
//  per good frame, and sends an ACK/NAK (plus read data) to the UART transmitter over a valid/ready handshake.
// PARAMETERS
//  SYNC_BYTE       8'hA5   frame start marker; any other byte in IDLE is discarded
//  TIMEOUT_CLOCKS  50000   max idle clocks between bytes inside a frame (used only with UART_CMD_TIMEOUT_EN)
// PORTS
//  clock        in   1  single system clock, all logic on rising edge
//  reset        in   1  asynchronous, active-high; clears all state and outputs immediately
//  rx_valid     in   1  one-cycle strobe from receiver: rx_data holds a new byte; no backpressure possible
//  rx_data      in   8  received byte
//  tx_data      out  8  response byte to transmitter
//  tx_valid     out  1  tx_data valid; held with tx_data stable until tx_ready
//  tx_ready     in   1  transmitter accepts tx_data when tx_valid && tx_ready on a clock edge
//  reg_addr     out  7  register address (CMD[6:0])
//  reg_wdata    out  8  register write data
//  reg_write    out  1  one-cycle write strobe
//  reg_read     out  1  one-cycle read strobe
//  reg_rdata    in   8  read data, valid exactly 1 cycle after reg_read
//  busy         out  1  high in every state except IDLE
//  error_count  out  8  saturating count of bad checksums, timeouts, dropped bytes (sticks at 8'hFF)
// BEHAVIOUR
//  - Reset: state IDLE; tx_valid, reg_write, reg_read, busy = 0; tx_data, reg_addr, reg_wdata, error_count = 0.
//  - Frame: SYNC, CMD (bit7 1=write 0=read, [6:0] addr), DATA (write only), CHECK = CMD ^ DATA (write) or CMD (read).
//  - FSM: IDLE -SYNC-> CMD -write-> DATA -> CHECK ; CMD -read-> CHECK.
//    CHECK match -> EXEC; mismatch -> RESP sending NAK 8'h15, error_count += 1.
//    EXEC (1 cycle): write -> reg_write=1, ACK 8'h06 queued; read -> reg_read=1, then RD_WAIT (1 cycle) samples
//    reg_rdata. RESP: ACK then rdata for reads, ACK or NAK alone otherwise; each byte held until tx_ready; then IDLE.
//  - Latency: CHECK byte strobe -> reg strobe next cycle; write ACK tx_valid asserts cycle after reg_write.
//  - rx_valid in EXEC/RD_WAIT/RESP: byte dropped, error_count += 1; FSM unaffected.
//  - SYNC_BYTE received mid-frame is treated as ordinary CMD/DATA/CHECK data (no resync).
//  - tx_valid never deasserts without a handshake except on reset; tx_ready ignored while tx_valid=0.
//  - Saturation: error_count at 8'hFF plus further errors stays 8'hFF.
//  - Reset mid-frame/mid-response: frame abandoned, tx_valid drops asynchronously, no register strobe issued.
// CONFIGURATION
//  UART_CMD_TIMEOUT_EN defined: counter clears on every rx_valid; in CMD/DATA/CHECK, after TIMEOUT_CLOCKS
//    cycles with no rx_valid -> IDLE silently (no NAK), error_count += 1. rx_valid in the expiry cycle wins
//    (byte consumed, no timeout). Counter idle outside those states.
//  Not defined: no counter; FSM waits indefinitely for the next byte; TIMEOUT_CLOCKS unused.
// STRUCTURE
//  Shared package/header uart_command_pkg: state encoding, ACK (8'h06), NAK (8'h15), CMD_WRITE_BIT (7).
//  Single module, no sub-modules; FSM, checksum register, response sequencer inline.
// TESTING
//  1. A5 85 3C B9 -> reg_write pulse, addr 05, wdata 3C; tx 06; error_count 0.
//  2. A5 12 12, reg_rdata=77 -> reg_read addr 12; tx 06 then 77; hold tx_ready low 10 cycles, data stable.
//  3. A5 85 3C 00 -> no reg strobe; tx 15; error_count 1.
//  4. 00 FF A5 01 01 -> junk bytes ignored (no error), read addr 01 completes; bytes sent during RESP counted.
//  5. With UART_CMD_TIMEOUT_EN, TIMEOUT_CLOCKS=20: A5 then 20 idle cycles -> IDLE, error_count+1, no tx;
//     repeat with byte on cycle 20 -> frame continues.
//  6. Assert reset during RESP with tx_valid=1 -> tx_valid 0 without a clock edge; next good frame works.

Source files
------------

// File: rtl/uart_command_pkg.sv
// rtl/uart_command_pkg.sv - shared state encoding and response codes for the UART command controller
package uart_command_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_EXEC    = 3'd4;
    localparam logic [2:0] ST_RD_WAIT = 3'd5;
    localparam logic [2:0] ST_RESP    = 3'd6;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
    localparam int CMD_WRITE_BIT = 7;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_command_controller.sv
// rtl/uart_command_controller.sv - SYNC/CMD/DATA/CHECK frame decoder, register sequencer and ACK/NAK responder
module uart_command_controller
    import uart_command_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int TIMEOUT_CLOCKS = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_write,
    output logic       reg_read,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic [7:0] error_count
);

    logic [2:0] state_q, state_d;
    logic       is_write_q, is_write_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] csum_q, csum_d;
    logic [7:0] rdata_q, rdata_d;
    logic       send_rdata_q, send_rdata_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       reg_write_q, reg_write_d;
    logic       reg_read_q, reg_read_d;
    logic [7:0] error_count_q, error_count_d;
    logic       err_inc;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CLOCKS + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             in_frame;
    assign in_frame = (state_q == ST_CMD) || (state_q == ST_DATA) || (state_q == ST_CHECK);
`endif

    always_comb begin
        state_d       = state_q;
        is_write_d    = is_write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        csum_d        = csum_q;
        rdata_d       = rdata_q;
        send_rdata_d  = send_rdata_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        reg_write_d   = 1'b0;
        reg_read_d    = 1'b0;
        err_inc       = 1'b0;
        error_count_d = error_count_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (rx_valid) begin
                    is_write_d = rx_data[CMD_WRITE_BIT];
                    addr_d     = rx_data[6:0];
                    csum_d     = rx_data;
                    state_d    = rx_data[CMD_WRITE_BIT] ? ST_DATA : ST_CHECK;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    wdata_d = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d     = ST_EXEC;
                        reg_write_d = is_write_q;
                        reg_read_d  = !is_write_q;
                    end else begin
                        state_d      = ST_RESP;
                        tx_valid_d   = 1'b1;
                        tx_data_d    = NAK;
                        send_rdata_d = 1'b0;
                        err_inc      = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                err_inc = rx_valid;
                if (is_write_q) begin
                    state_d      = ST_RESP;
                    tx_valid_d   = 1'b1;
                    tx_data_d    = ACK;
                    send_rdata_d = 1'b0;
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                err_inc      = rx_valid;
                rdata_d      = reg_rdata;
                state_d      = ST_RESP;
                tx_valid_d   = 1'b1;
                tx_data_d    = ACK;
                send_rdata_d = 1'b1;
            end
            ST_RESP: begin
                err_inc = rx_valid;
                if (tx_ready) begin
                    if (send_rdata_q) begin
                        tx_data_d    = rdata_q;
                        send_rdata_d = 1'b0;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef UART_CMD_TIMEOUT_EN
        tmo_cnt_d = '0;
        if (in_frame && !rx_valid) begin
            if (tmo_cnt_q == TMO_W'(TIMEOUT_CLOCKS - 1)) begin
                state_d = ST_IDLE;
                err_inc = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end
`endif

        if (err_inc) error_count_d = sat_inc(error_count_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            is_write_q    <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            csum_q        <= '0;
            rdata_q       <= '0;
            send_rdata_q  <= 1'b0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            reg_write_q   <= 1'b0;
            reg_read_q    <= 1'b0;
            error_count_q <= '0;
        end else begin
            state_q       <= state_d;
            is_write_q    <= is_write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            csum_q        <= csum_d;
            rdata_q       <= rdata_d;
            send_rdata_q  <= send_rdata_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            reg_write_q   <= reg_write_d;
            reg_read_q    <= reg_read_d;
            error_count_q <= error_count_d;
        end
    end

`ifdef UART_CMD_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) tmo_cnt_q <= '0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end
`endif

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign reg_addr    = addr_q;
    assign reg_wdata   = wdata_q;
    assign reg_write   = reg_write_q;
    assign reg_read    = reg_read_q;
    assign busy        = (state_q != ST_IDLE);
    assign error_count = error_count_q;

endmodule

// File: tb/tb_uart_command_controller.sv
// tb/tb_uart_command_controller.sv - scoreboard bench for uart_command_controller
module tb_uart_command_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_write;
    logic       reg_read;
    logic [7:0] reg_rdata = 8'hEE;
    logic       busy;
    logic [7:0] error_count;

    uart_command_controller #(.TIMEOUT_CLOCKS(20)) dut (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_write(reg_write),
        .reg_read(reg_read), .reg_rdata(reg_rdata), .busy(busy), .error_count(error_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       wr;
        logic [6:0] addr;
        logic [7:0] wdata;
    } regop_t;

    regop_t     regop_q[$];
    logic [7:0] tx_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_err = 8'h00;
    logic [7:0] rdata_val = 8'h00;
    logic       rd_prev;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] err_plus(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always begin
        @(negedge clock);
        rd_prev = reg_read;
        @(posedge clock);
        #1;
        reg_rdata = rd_prev ? rdata_val : 8'hEE;
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (reg_write || reg_read) begin
                if (regop_q.size() == 0) begin
                    check_eq("regop_unexpected", {reg_write, reg_read}, 0);
                end else begin
                    regop_t e;
                    e = regop_q.pop_front();
                    check_eq("reg_kind", {reg_write, reg_read}, {e.wr, !e.wr});
                    check_eq("reg_addr", reg_addr, e.addr);
                    if (e.wr) check_eq("reg_wdata", reg_wdata, e.wdata);
                end
            end
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) check_eq("tx_unexpected", tx_data, 32'h100);
                else check_eq("tx_byte", tx_data, tx_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic frame_write(input logic [6:0] addr, input logic [7:0] data, input logic [7:0] chk);
        logic [7:0] cmd;
        regop_t     e;
        cmd = {1'b1, addr};
        if (chk == (cmd ^ data)) begin
            e.wr = 1'b1; e.addr = addr; e.wdata = data;
            regop_q.push_back(e);
            tx_q.push_back(8'h06);
        end else begin
            tx_q.push_back(8'h15);
            exp_err = err_plus(exp_err);
        end
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(data);
        send_byte(chk);
    endtask

    task automatic frame_read(input logic [6:0] addr, input logic [7:0] chk, input logic [7:0] rd);
        regop_t e;
        rdata_val = rd;
        if (chk == {1'b0, addr}) begin
            e.wr = 1'b0; e.addr = addr; e.wdata = 8'h00;
            regop_q.push_back(e);
            tx_q.push_back(8'h06);
            tx_q.push_back(rd);
        end else begin
            tx_q.push_back(8'h15);
            exp_err = err_plus(exp_err);
        end
        send_byte(8'hA5);
        send_byte({1'b0, addr});
        send_byte(chk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            idle(1);
            n++;
        end
        check_eq(tag, busy, 0);
    endtask

    task automatic wait_tx_valid(input string tag);
        int n = 0;
        while (!tx_valid && n < 50) begin
            idle(1);
            n++;
        end
        check_eq(tag, tx_valid, 1);
    endtask

    initial begin
        logic [7:0] held;

        #1;
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_outputs", {tx_data, reg_addr, reg_wdata, reg_write, reg_read, busy, error_count}, 0);
        idle(2);
        reset = 1'b0;
        idle(1);

        frame_write(7'h05, 8'h3C, 8'hB9);
        check_eq("wr_strobe_latency", reg_write, 1);
        check_eq("wr_ack_not_yet", tx_valid, 0);
        idle(1);
        check_eq("wr_ack_latency", {tx_valid, tx_data}, {1'b1, 8'h06});
        wait_idle("wr_idle");
        check_eq("wr_err", error_count, exp_err);

        tx_ready = 1'b0;
        frame_read(7'h12, 8'h12, 8'h77);
        check_eq("rd_strobe_latency", reg_read, 1);
        wait_tx_valid("rd_tx_valid");
        held = tx_data;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            check_eq("rd_hold", {tx_valid, tx_data}, {1'b1, held});
        end
        tx_ready = 1'b1;
        wait_idle("rd_idle");

        frame_write(7'h05, 8'h3C, 8'h00);
        wait_idle("nak_idle");
        check_eq("nak_err", error_count, exp_err);

        send_byte(8'h00);
        send_byte(8'hFF);
        check_eq("junk_no_err", error_count, exp_err);
        tx_ready = 1'b0;
        frame_read(7'h01, 8'h01, 8'hC3);
        send_byte(8'h55);
        send_byte(8'hA5);
        exp_err = err_plus(err_plus(exp_err));
        wait_tx_valid("drop_tx_valid");
        send_byte(8'h11);
        exp_err = err_plus(exp_err);
        tx_ready = 1'b1;
        wait_idle("drop_idle");
        check_eq("drop_err", error_count, exp_err);

`ifdef UART_CMD_TIMEOUT_EN
        send_byte(8'hA5);
        idle(20);
        exp_err = err_plus(exp_err);
        check_eq("tmo_busy", busy, 0);
        check_eq("tmo_err", error_count, exp_err);
        check_eq("tmo_no_tx", tx_valid, 0);
        frame_read(7'h20, 8'h20, 8'h9A);
        wait_idle("pre_edge_idle");
        regop_q.push_back('{wr: 1'b0, addr: 7'h21, wdata: 8'h00});
        tx_q.push_back(8'h06);
        tx_q.push_back(8'h5A);
        rdata_val = 8'h5A;
        send_byte(8'hA5);
        idle(19);
        check_eq("tmo_edge_busy", busy, 1);
        send_byte(8'h21);
        send_byte(8'h21);
        wait_idle("tmo_edge_idle");
        check_eq("tmo_edge_err", error_count, exp_err);
`endif

        tx_ready = 1'b0;
        frame_write(7'h33, 8'h44, 8'hB3 ^ 8'h44);
        wait_tx_valid("sat_tx_valid");
        for (int i = 0; i < 260; i++) begin
            send_byte(i[7:0]);
            exp_err = err_plus(exp_err);
        end
        check_eq("sat_err", error_count, exp_err);
        check_eq("sat_ff", error_count, 8'hFF);
        tx_ready = 1'b1;
        wait_idle("sat_idle");

        tx_ready = 1'b0;
        frame_write(7'h0A, 8'h0B, 8'h8A ^ 8'h0B);
        wait_tx_valid("rst_resp_tx_valid");
        #2;
        reset = 1'b1;
        tx_q.delete();
        regop_q.delete();
        exp_err = 8'h00;
        #1;
        check_eq("async_tx_valid", tx_valid, 0);
        check_eq("async_busy_err", {busy, error_count}, 0);
        idle(1);
        reset = 1'b0;
        tx_ready = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h85);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(3);
        check_eq("midframe_rst_busy", busy, 0);
        frame_read(7'h7F, 8'h7F, 8'h3E);
        wait_idle("post_rst_idle");
        check_eq("post_rst_err", error_count, exp_err);

        idle(3);
        check_eq("tx_queue_empty", tx_q.size(), 0);
        check_eq("regop_queue_empty", regop_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
